// File: rtl/window_fetch_if.sv
// Bundle of handshake and memory signals for window_fetch.
// slave is the fetch block itself; master is whoever drives anchors, the RAM and the consumer.
interface window_fetch_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32,
    parameter int NW     = 25
);
    logic [ADDR_W-1:0]    anchor_addr;
    logic                 anchor_valid;
    logic                 anchor_ready;
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_rdata;
    logic [DATA_W*NW-1:0] win_data;
    logic                 win_valid;
    logic                 win_ready;
    logic                 win_last;

    modport slave (
        input  anchor_addr, anchor_valid, mem_rdata, win_ready,
        output anchor_ready, mem_rd_en, mem_addr, win_data, win_valid, win_last
    );

    modport master (
        output anchor_addr, anchor_valid, mem_rdata, win_ready,
        input  anchor_ready, mem_rd_en, mem_addr, win_data, win_valid, win_last
    );
endinterface

// File: rtl/window_fetch.sv
// window_fetch: reads one HxV window from a single-port image RAM, one pixel per
// cycle, packs it into a flat word and flags the last window of each frame.
module window_fetch #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 32,
    parameter int H_WINDOW_LEN = 5,
    parameter int V_WINDOW_LEN = 5,
    parameter int H_IMAGE_LEN  = 30,
    parameter int V_IMAGE_LEN  = 30,
    parameter int RD_LATENCY   = 1
) (
    input  logic            clk,
    input  logic            rst,
    window_fetch_if.slave   bus
);
    localparam int NW    = H_WINDOW_LEN * V_WINDOW_LEN;
    localparam int NWIN  = (H_IMAGE_LEN - H_WINDOW_LEN + 1) * (V_IMAGE_LEN - V_WINDOW_LEN + 1);
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int CNT_W = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int HC_W  = (H_WINDOW_LEN > 1) ? $clog2(H_WINDOW_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic                 accept_s;
    logic                 last_rd_s;
    logic                 cap_last_s;
    logic                 hshake_s;

    logic                 anchor_ready_r;
    logic                 mem_rd_en_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [ADDR_W-1:0]    row_base_r;
    logic [HC_W-1:0]      h_cnt_r;
    logic [IDX_W-1:0]     rd_idx_r;
    logic [DATA_W*NW-1:0] win_data_r;
    logic                 win_valid_r;
    logic                 win_last_r;
    logic [CNT_W-1:0]     win_cnt_r;
    logic                 pipe_vld_r [RD_LATENCY];
    logic [IDX_W-1:0]     pipe_idx_r [RD_LATENCY];

    assign bus.anchor_ready = anchor_ready_r;
    assign bus.mem_rd_en    = mem_rd_en_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.win_data     = win_data_r;
    assign bus.win_valid    = win_valid_r;
    assign bus.win_last     = win_last_r;

    // Tag emerging from the read pipe that carries the final pixel of the window.
    assign cap_last_s = pipe_vld_r[RD_LATENCY-1] &&
                        (pipe_idx_r[RD_LATENCY-1] == IDX_W'(NW - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and event decode.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_rd_s    = 1'b0;
        hshake_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.anchor_valid && anchor_ready_r) begin
                    accept_s     = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                if (rd_idx_r == IDX_W'(NW - 1)) begin
                    last_rd_s    = 1'b1;
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = FETCH;
                end
            end
            DRAIN: begin
                if (cap_last_s) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            HOLD: begin
                if (bus.win_ready) begin
                    hshake_s     = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Registered status outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            anchor_ready_r <= 1'b0;
            mem_rd_en_r    <= 1'b0;
            win_valid_r    <= 1'b0;
        end else begin
            anchor_ready_r <= (state_next_s == IDLE);
            mem_rd_en_r    <= (state_next_s == FETCH);
            win_valid_r    <= (state_next_s == HOLD);
        end
    end

    // Address walker: step along the row, then jump to the next row base by the stride.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_r <= {ADDR_W{1'b0}};
            row_base_r <= {ADDR_W{1'b0}};
            h_cnt_r    <= {HC_W{1'b0}};
            rd_idx_r   <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            mem_addr_r <= bus.anchor_addr;
            row_base_r <= bus.anchor_addr;
            h_cnt_r    <= {HC_W{1'b0}};
            rd_idx_r   <= {IDX_W{1'b0}};
        end else if ((state_r == FETCH) && !last_rd_s) begin
            rd_idx_r <= rd_idx_r + IDX_W'(1);
            if (h_cnt_r == HC_W'(H_WINDOW_LEN - 1)) begin
                h_cnt_r    <= {HC_W{1'b0}};
                row_base_r <= row_base_r + ADDR_W'(H_IMAGE_LEN);
                mem_addr_r <= row_base_r + ADDR_W'(H_IMAGE_LEN);
            end else begin
                h_cnt_r    <= h_cnt_r + HC_W'(1);
                mem_addr_r <= mem_addr_r + ADDR_W'(1);
            end
        end else begin
            mem_addr_r <= mem_addr_r;
        end
    end

    // Read tag pipe: tracks which slot each returning RAM word belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld_r[i] <= 1'b0;
                pipe_idx_r[i] <= {IDX_W{1'b0}};
            end
        end else begin
            pipe_vld_r[0] <= mem_rd_en_r;
            pipe_idx_r[0] <= rd_idx_r;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_idx_r[i] <= pipe_idx_r[i-1];
            end
        end
    end

    // Pixel capture into the packed window word when a valid tag emerges.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_data_r <= {(DATA_W*NW){1'b0}};
        end else if (pipe_vld_r[RD_LATENCY-1]) begin
            win_data_r[DATA_W*int'(pipe_idx_r[RD_LATENCY-1]) +: DATA_W] <= bus.mem_rdata;
        end else begin
            win_data_r <= win_data_r;
        end
    end

    // Frame window counter and last-window flag, frozen while the window is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_r  <= {CNT_W{1'b0}};
            win_last_r <= 1'b0;
        end else begin
            if ((state_r == DRAIN) && cap_last_s) begin
                win_last_r <= (win_cnt_r == CNT_W'(NWIN - 1));
            end else if (hshake_s) begin
                win_last_r <= 1'b0;
            end else begin
                win_last_r <= win_last_r;
            end
            if (hshake_s) begin
                if (win_cnt_r == CNT_W'(NWIN - 1)) begin
                    win_cnt_r <= {CNT_W{1'b0}};
                end else begin
                    win_cnt_r <= win_cnt_r + CNT_W'(1);
                end
            end else begin
                win_cnt_r <= win_cnt_r;
            end
        end
    end
endmodule
